// File: rtl/fp_add_sched_pkg.sv
// Shared constants and helpers for the FP_ADD round-robin scheduler.
package fp_add_sched_pkg;

    localparam int FP_W     = 32;
    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id);
        logic [MAX_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping) wins; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one pipelined FP_ADD between NUM_REQ clients,
// with a tag pipe that routes each adder result back to its issuer.
module fp_add_sched
    import fp_add_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 7,
    localparam int ID_W  = $clog2(NUM_REQ),
    localparam int CNT_W = $clog2(LATENCY + 2)
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [FP_W-1:0]         fp_a,
    output logic [FP_W-1:0]         fp_b,
    input  logic [FP_W-1:0]         fp_q,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    idle
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0] grant;
    logic               handshake;
    logic [ID_W-1:0]    grantId;
    logic               retire;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [FP_W-1:0]  fpA_q, fpA_d;
    logic [FP_W-1:0]  fpB_q, fpB_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tag_t             tagIn_d;

    // Stage 0 is aligned with the operand registers; the LATENCY stages after
    // it track the adder, so the last stage lines up with fp_q.
    tag_t tagPipe_q [LATENCY+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) uArb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign handshake = |grant;
    assign retire    = tagPipe_q[LATENCY].valid;

    always_comb begin
        grantId = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grantId = ID_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        fpA_d         = fpA_q;
        fpB_d         = fpB_q;
        tagIn_d.valid = handshake;
        tagIn_d.id    = handshake ? grantId : '0;
        if (handshake) begin
            fpA_d = req_a[int'(grantId)*FP_W +: FP_W];
            fpB_d = req_b[int'(grantId)*FP_W +: FP_W];
            ptr_d = (int'(grantId) == NUM_REQ - 1) ? '0 : grantId + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (handshake && !retire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!handshake && retire) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr_q <= '0;
            fpA_q <= '0;
            fpB_q <= '0;
            cnt_q <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tagPipe_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            fpA_q        <= fpA_d;
            fpB_q        <= fpB_d;
            cnt_q        <= cnt_d;
            tagPipe_q[0] <= tagIn_d;
            for (int s = 1; s <= LATENCY; s++) begin
                tagPipe_q[s] <= tagPipe_q[s-1];
            end
        end
    end

    // The adder cannot stall, so results are strobed straight through.
    assign rsp_valid   = retire ? NUM_REQ'(onehot(MAX_ID_W'(tagPipe_q[LATENCY].id))) : '0;
    assign rsp_data    = fp_q;
    assign fp_a        = fpA_q;
    assign fp_b        = fpB_q;
    assign outstanding = cnt_q;
    assign idle        = (cnt_q == '0) && !(|req_valid);

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched with a behavioural FP_ADD stand-in.
module tb_fp_add_sched;

    localparam int NREQ  = 4;
    localparam int L     = 3;
    localparam int CNT_W = $clog2(L + 2);

    logic                 clk = 1'b0;
    logic                 areset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [31:0]          fp_a;
    logic [31:0]          fp_b;
    logic [31:0]          fp_q;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic [CNT_W-1:0]     outstanding;
    logic                 idle;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          grantCycles[$];
    int          cyc = 0;
    int          nChecks = 0;
    int          nFails = 0;
    int          mPtr = 0;
    logic [31:0] modelA = '0;
    logic [31:0] modelB = '0;
    logic [31:0] fpPipe [L];

    fp_add_sched #(
        .NUM_REQ (NREQ),
        .LATENCY (L)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .fp_a        (fp_a),
        .fp_b        (fp_b),
        .fp_q        (fp_q),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .outstanding (outstanding),
        .idle        (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder stand-in: exact for normals/zero, truncating; the scheduler never
    // looks at the values, it only has to route them.
    function automatic real toReal(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fromReal(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] fpAdd(input logic [31:0] x, input logic [31:0] y);
        return fromReal(toReal(x) + toReal(y));
    endfunction

    function automatic logic [31:0] randFp();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = 8'($urandom_range(100, 150));
        r[22:0]  = 23'($urandom);
        return r;
    endfunction

    function automatic logic [NREQ*32-1:0] pack4(input logic [31:0] x0, input logic [31:0] x1,
                                                 input logic [31:0] x2, input logic [31:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [NREQ*32-1:0] randOps();
        logic [NREQ*32-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*32 +: 32] = randFp();
        return v;
    endfunction

    always @(posedge clk) begin
        fpPipe[0] <= fpAdd(fp_a, fp_b);
        for (int s = 1; s < L; s++) fpPipe[s] <= fpPipe[s-1];
    end
    assign fp_q = fpPipe[L-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*32-1:0] a,
                                 input logic [NREQ*32-1:0] b);
        logic [NREQ-1:0] expGrant;
        int              g;
        int              idx;
        exp_t            e;
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        checkOutput("fp_a", fp_a, modelA);
        checkOutput("fp_b", fp_b, modelB);
        expGrant = '0;
        g        = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mPtr + k) % NREQ;
            if (g < 0 && valid[idx]) g = idx;
        end
        if (g >= 0) expGrant[g] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
        if (g >= 0) begin
            e.id   = g;
            e.data = fpAdd(a[g*32 +: 32], b[g*32 +: 32]);
            e.due  = cyc + L + 1;
            sbq.push_back(e);
            grantCycles.push_back(cyc);
            modelA = a[g*32 +: 32];
            modelB = b[g*32 +: 32];
            mPtr   = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0);
    endtask

    // Holds reset for n cycles; all in-flight work is forgotten.
    task automatic resetPulse(input int n);
        areset    = 1'b1;
        req_valid = '0;
        sbq.delete();
        grantCycles.delete();
        mPtr   = 0;
        modelA = '0;
        modelB = '0;
        @(negedge clk);
        checkOutput("rst_fp_a", fp_a, 32'h0);
        checkOutput("rst_fp_b", fp_b, 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'h0);
        checkOutput("rst_idle", 32'(idle), 32'h1);
        repeat (n - 1) @(posedge clk);
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    always @(negedge clk) begin
        int   t;
        int   cnt;
        logic expIdle;
        exp_t e;
        if (areset !== 1'b1) begin
            t   = cyc;
            cnt = 0;
            while (grantCycles.size() > 0 && grantCycles[0] < t - L - 1) void'(grantCycles.pop_front());
            foreach (grantCycles[i]) if (grantCycles[i] <= t - 1) cnt++;
            expIdle = (cnt == 0) && (req_valid == '0);
            checkOutput("outstanding", 32'(outstanding), 32'(cnt));
            checkOutput("idle", 32'(idle), 32'(expIdle));
            if (sbq.size() > 0 && sbq[0].due < t) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL rsp_missing: got none, expected req %0d due cycle %0d (cycle %0d)",
                         sbq[0].id, sbq[0].due, t);
                void'(sbq.pop_front());
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rsp_cycle", 32'(t), 32'(e.due));
                    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                    checkOutput("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        resetPulse(2);

        $display("[TB] single operation");
        applyStimulus(4'b0001, pack4(32'h0000_0000, '0, '0, '0), pack4(32'h3f80_0000, '0, '0, '0));
        idleCycles(L + 2);

        $display("[TB] round robin, all requesters");
        for (int i = 0; i < 12; i++) applyStimulus(4'b1111, randOps(), randOps());
        idleCycles(L + 2);

        $display("[TB] per-requester routing");
        applyStimulus(4'b0010, pack4('0, 32'h3f80_0000, '0, '0), pack4('0, 32'h3f80_0000, '0, '0));
        applyStimulus(4'b0100, pack4('0, '0, 32'h3fc0_0000, '0), pack4('0, '0, 32'h4020_0000, '0));
        idleCycles(L + 2);

        $display("[TB] fairness and hold");
        for (int i = 0; i < 5; i++) applyStimulus(4'b1000, randOps(), randOps());
        for (int i = 0; i < 6; i++) applyStimulus(4'b1001, randOps(), randOps());
        idleCycles(L + 2);

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, randOps(), randOps());
        resetPulse(1);
        idleCycles(L + 2);

        $display("[TB] steady stream from requester 0");
        for (int i = 0; i < 20; i++) applyStimulus(4'b0001, randOps(), randOps());
        idleCycles(L + 3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(NREQ'($urandom_range(0, (1 << NREQ) - 1)), randOps(), randOps());
        end
        idleCycles(L + 3);

        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fp_add_sched.md
Name: fp_add_sched

Overview:
Round-robin scheduler that shares one pipelined FP_ADD instance (single-precision, fixed latency, no stall input) between NUM_REQ requesters. It accepts at most one operand pair per cycle and drives the adder's a/b inputs from a registered issue stage. A tag pipeline matched to the adder latency routes each q result back to the requester that issued it. It sits between compute clients and the FP_ADD core. FP_ADD is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
LATENCY, 7, FP_ADD pipeline depth in cycles (operands sampled -> q valid), >=1
ID_W, $clog2(NUM_REQ), width of the requester tag (derived, not overridden)

Ports:
clk  input  1  system clock
areset  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  per-requester grant; handshake = valid & ready
req_a  input  NUM_REQ*32  operand A, packed, requester i at [32i+:32]
req_b  input  NUM_REQ*32  operand B, packed
fp_a  output  32  to FP_ADD a
fp_b  output  32  to FP_ADD b
fp_q  input  32  from FP_ADD q
rsp_valid  output  NUM_REQ  one-hot result strobe, 1 cycle
rsp_data  output  32  result, valid when any rsp_valid bit is set
outstanding  output  $clog2(LATENCY+2)  operations in flight
idle  output  1  high when outstanding==0 and no req_valid is set

Behaviour:
- Reset (async assert, sync release): fp_a=0, fp_b=0, rsp_valid=0, rsp_data is don't-care, outstanding=0, priority pointer=0, all tag-pipe valid bits=0.
- Arbitration: combinational round-robin over req_valid, starting at the priority pointer. At most one req_ready bit is high, and only for a requester with req_valid=1. req_ready depends on req_valid. Requesters must not make req_valid wait on req_ready.
- On handshake of requester g, the priority pointer becomes (g+1) mod NUM_REQ. With no handshake the pointer holds.
- Issue stage: on the handshake edge, fp_a/fp_b register req_a[g]/req_b[g]. A tag entry {valid=1, id=g} enters stage 0 of the tag pipe. With no handshake, fp_a/fp_b hold their values and a valid=0 entry enters the pipe.
- Tag pipe: LATENCY-deep shift register advancing every cycle unconditionally. The adder never stalls, so there is no backpressure on responses.
- Timing: handshake in cycle 0, operands on fp_a/fp_b in cycle 1, result on fp_q and rsp_valid[id] in cycle 1+LATENCY. Total request-to-response latency is LATENCY+1 cycles.
- Response: rsp_valid = onehot(id) & valid of the last tag stage. rsp_data = fp_q (combinational pass-through). Clients must capture it in the strobe cycle.
- Throughput: one operation per cycle sustained. A single requester holding req_valid high when no other requester is active is granted every cycle.
- outstanding: +1 on handshake, -1 when a response is emitted, unchanged when both happen in one cycle. Maximum value is LATENCY+1.
- Asserting areset mid-operation clears all in-flight tags immediately. No response is emitted after release for operations issued before reset, even though FP_ADD may still hold stale data.
- Results are not interpreted: NaN/Inf/denormal results are passed through unchanged.

Decomposition:
- Package fp_add_sched_pkg:
  - FP_W=32.
  - tag_t struct {logic valid; logic [ID_W-1:0] id} (parameterised via localparam in the module if the package cannot see NUM_REQ).
  - Function for the one-hot decode.
- Sub-module rr_arbiter (NUM_REQ): inputs req and pointer, output one-hot grant; purely combinational. The pointer register lives in fp_add_sched.

Test Plan:
- Reset/single op, LATENCY=3: release reset; req_valid[0] with a=0x00000000, b=0x3f800000 in cycle 0 -> req_ready[0]=1 in cycle 0; fp_a/fp_b=0/0x3f800000 in cycle 1; rsp_valid=4'b0001, rsp_data=0x3f800000 in cycle 4; outstanding 1 during cycles 1..4, 0 after.
- Round robin: all 4 requesters valid continuously, pointer=0 -> grants in order 0,1,2,3,0,... one per cycle; responses arrive in the same order, LATENCY+1 cycles after each grant.
- Per-requester routing: req1 1.0+1.0, req2 1.5+2.5 in consecutive cycles -> rsp_valid[1] with 0x40000000, then rsp_valid[2] next cycle with 0x40800000.
- Fairness/hold: req3 is the only valid requester for 5 cycles, then req0 joins -> req3 is granted 5 times, then req0 and req3 alternate; no requester is starved for more than NUM_REQ-1 cycles.
- Reset mid-flight: issue 3 ops, assert areset for 1 cycle at cycle 2 -> rsp_valid stays 0 for LATENCY+2 cycles after release; outstanding=0; idle=1.
- Simultaneous issue/retire: steady stream from req0 -> outstanding saturates at LATENCY+1 and stays constant; idle=0 until the stream stops and LATENCY+1 cycles pass.
